// File: rtl/math_op_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared G.729 basic-op units.
// Per-requester buses are packed with requester i at slice i.
interface math_op_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // Handshakes: a requester raises req[i] and keeps it high for its whole ownership
  // period; it may drive the shared units only while grant[i]=1. rq_L_shlReady is a
  // one-cycle start strobe honoured only from the owner; L_shlDone is a one-cycle
  // completion pulse from the unit, returned on L_shlDoneOut to the owner only.
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [16*NUM_REQ-1:0] rq_L_multA;
  logic [16*NUM_REQ-1:0] rq_L_multB;
  logic [16*NUM_REQ-1:0] rq_L_macA;
  logic [16*NUM_REQ-1:0] rq_L_macB;
  logic [32*NUM_REQ-1:0] rq_L_macC;
  logic [16*NUM_REQ-1:0] rq_L_msuA;
  logic [16*NUM_REQ-1:0] rq_L_msuB;
  logic [32*NUM_REQ-1:0] rq_L_msuC;
  logic [16*NUM_REQ-1:0] rq_multA;
  logic [16*NUM_REQ-1:0] rq_multB;
  logic [32*NUM_REQ-1:0] rq_L_shlVar1;
  logic [16*NUM_REQ-1:0] rq_L_shlNumShift;
  logic [NUM_REQ-1:0]    rq_L_shlReady;
  logic [15:0]           L_multOutA;
  logic [15:0]           L_multOutB;
  logic [15:0]           L_macOutA;
  logic [15:0]           L_macOutB;
  logic [31:0]           L_macOutC;
  logic [15:0]           L_msuOutA;
  logic [15:0]           L_msuOutB;
  logic [31:0]           L_msuOutC;
  logic [15:0]           multOutA;
  logic [15:0]           multOutB;
  logic [31:0]           L_shlVar1Out;
  logic [15:0]           L_shlNumShiftOut;
  logic                  L_shlReady;
  logic                  L_shlDone;
  logic [NUM_REQ-1:0]    L_shlDoneOut;
  logic                  busy;
  logic                  hold_err;
  logic                  dbg_owned;

  modport slave (
    input  req, rq_L_multA, rq_L_multB, rq_L_macA, rq_L_macB, rq_L_macC,
           rq_L_msuA, rq_L_msuB, rq_L_msuC, rq_multA, rq_multB,
           rq_L_shlVar1, rq_L_shlNumShift, rq_L_shlReady, L_shlDone,
    output grant, L_multOutA, L_multOutB, L_macOutA, L_macOutB, L_macOutC,
           L_msuOutA, L_msuOutB, L_msuOutC, multOutA, multOutB,
           L_shlVar1Out, L_shlNumShiftOut, L_shlReady, L_shlDoneOut,
           busy, hold_err, dbg_owned
  );

  modport master (
    output req, rq_L_multA, rq_L_multB, rq_L_macA, rq_L_macB, rq_L_macC,
           rq_L_msuA, rq_L_msuB, rq_L_msuC, rq_multA, rq_multB,
           rq_L_shlVar1, rq_L_shlNumShift, rq_L_shlReady, L_shlDone,
    input  grant, L_multOutA, L_multOutB, L_macOutA, L_macOutB, L_macOutC,
           L_msuOutA, L_msuOutB, L_msuOutC, multOutA, multOutB,
           L_shlVar1Out, L_shlNumShiftOut, L_shlReady, L_shlDoneOut,
           busy, hold_err, dbg_owned
  );
endinterface

// File: rtl/math_op_arbiter.sv
// Round-robin owner arbiter sharing one set of G.729 basic-op units between NUM_REQ
// requesters; the owner keeps the units while req is high or an L_shl is in flight.
module math_op_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int MAX_HOLD = 255
) (
  input logic              clk,
  input logic              reset,
  math_op_arbiter_if.slave bus
);
  localparam int          PW         = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [15:0] MAX_HOLD_C = 16'(MAX_HOLD);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               hold_err_q, hold_err_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;

  logic               shl_ready;
  logic               release_own;
  logic [PW-1:0]      next_ptr;
  logic [PW:0]        pick;
  logic [NUM_REQ-1:0] others_req;

  // {found, index} of the first set request at or after p, wrapping upward.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0] p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = (int'(p) + j) % NUM_REQ;
      if (r[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  assign shl_ready = |(bus.rq_L_shlReady & grant_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    next_ptr   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    // A strobe on the release cycle starts an op, so ownership must stay with it.
    release_own = (state_q == OWNED) && !bus.req[owner_q] && !busy_q && !shl_ready;
    pick       = rr_pick(bus.req, (state_q == OWNED) ? next_ptr : ptr_q);

    if (state_q == IDLE || release_own) begin
      if (release_own) ptr_d = next_ptr;
      grant_d = '0;
      if (pick[PW]) begin
        state_d              = OWNED;
        owner_d              = pick[PW-1:0];
        grant_d[pick[PW-1:0]] = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    // A new start wins over a completion landing on the same edge.
    if (shl_ready)          busy_d = 1'b1;
    else if (bus.L_shlDone) busy_d = 1'b0;
    else                    busy_d = busy_q;

    others_req = bus.req & ~grant_q;
    hold_cnt_d = hold_cnt_q;
    if (grant_d != grant_q)
      hold_cnt_d = '0;
    else if (state_q == OWNED && |others_req && hold_cnt_q != 16'hFFFF)
      hold_cnt_d = hold_cnt_q + 16'd1;
    hold_err_d = hold_err_q | (hold_cnt_d >= MAX_HOLD_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      hold_err_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      hold_err_q <= hold_err_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // AND-OR operand mux: grant is one-hot or zero, so no owner yields all zeros.
  always_comb begin
    bus.L_multOutA       = '0;
    bus.L_multOutB       = '0;
    bus.L_macOutA        = '0;
    bus.L_macOutB        = '0;
    bus.L_macOutC        = '0;
    bus.L_msuOutA        = '0;
    bus.L_msuOutB        = '0;
    bus.L_msuOutC        = '0;
    bus.multOutA         = '0;
    bus.multOutB         = '0;
    bus.L_shlVar1Out     = '0;
    bus.L_shlNumShiftOut = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        bus.L_multOutA       = bus.rq_L_multA[16*i +: 16];
        bus.L_multOutB       = bus.rq_L_multB[16*i +: 16];
        bus.L_macOutA        = bus.rq_L_macA[16*i +: 16];
        bus.L_macOutB        = bus.rq_L_macB[16*i +: 16];
        bus.L_macOutC        = bus.rq_L_macC[32*i +: 32];
        bus.L_msuOutA        = bus.rq_L_msuA[16*i +: 16];
        bus.L_msuOutB        = bus.rq_L_msuB[16*i +: 16];
        bus.L_msuOutC        = bus.rq_L_msuC[32*i +: 32];
        bus.multOutA         = bus.rq_multA[16*i +: 16];
        bus.multOutB         = bus.rq_multB[16*i +: 16];
        bus.L_shlVar1Out     = bus.rq_L_shlVar1[32*i +: 32];
        bus.L_shlNumShiftOut = bus.rq_L_shlNumShift[16*i +: 16];
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.hold_err     = hold_err_q;
  assign bus.L_shlReady   = shl_ready;
  assign bus.L_shlDoneOut = {NUM_REQ{bus.L_shlDone}} & grant_q;
  assign bus.dbg_owned    = (state_q == OWNED);
endmodule

// File: tb/tb_math_op_arbiter.sv
// Directed bench for math_op_arbiter: grant transitions go through an expected queue
// checked by a negedge monitor; datapath and status checks are made inline.
module tb_math_op_arbiter;
  localparam int N = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  math_op_arbiter_if #(.NUM_REQ(N)) bus ();

  math_op_arbiter #(.NUM_REQ(N), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] own;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference L_mac: acc + sat(a*b*2), saturated to 32 bits.
  function automatic logic [31:0] l_mac(input logic [31:0] c, input logic [15:0] a,
                                        input logic [15:0] b);
    logic signed [31:0] p;
    logic signed [32:0] s;
    p = $signed(a) * $signed(b);
    if (a == 16'h8000 && b == 16'h8000) p = 32'sh7FFFFFFF;
    else p = p <<< 1;
    s = $signed({c[31], c}) + $signed({p[31], p});
    if (s > 33'sh07FFFFFFF)       return 32'h7FFFFFFF;
    else if (s < -33'sh080000000) return 32'h80000000;
    else                          return s[31:0];
  endfunction

  always @(negedge clk) begin
    if (bus.grant !== prev_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_seq: got %b, want no change from %b", bus.grant, prev_grant);
      end else begin
        check("grant_seq", 32'(bus.grant), 32'(exp_q.pop_front()));
      end
      prev_grant <= bus.grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.req              = '0;
    bus.rq_L_multA       = {16'h1111, 16'h2222};
    bus.rq_L_multB       = {16'h3333, 16'h4444};
    bus.rq_L_macA        = '0;
    bus.rq_L_macB        = '0;
    bus.rq_L_macC        = '0;
    bus.rq_L_msuA        = '0;
    bus.rq_L_msuB        = '0;
    bus.rq_L_msuC        = '0;
    bus.rq_multA         = '0;
    bus.rq_multB         = '0;
    bus.rq_L_shlVar1     = '0;
    bus.rq_L_shlNumShift = '0;
    bus.rq_L_shlReady    = '0;
    bus.L_shlDone        = 1'b0;

    // Reset held with both requesting: nothing granted.
    reset   = 1'b0;
    bus.req = 2'b11;
    #2;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_hold_err", 32'(bus.hold_err), 32'h0);
    check("rst_multA_zero", 32'(bus.L_multOutA), 32'h0);
    exp_q.push_back(2'b01);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("t1_grant_latency", 32'(bus.grant), 32'h1);
    check("t1_multA_owner0", 32'(bus.L_multOutA), 32'h2222);

    // Operand mux from owner 0 and a hand-computed L_mac.
    bus.rq_L_macA = {16'h1234, 16'h4000};
    bus.rq_L_macB = {16'h0000, 16'h4000};
    bus.rq_L_macC = {32'h0, 32'h0};
    #1;
    check("t2_macA", 32'(bus.L_macOutA), 32'h4000);
    check("t2_macB", 32'(bus.L_macOutB), 32'h4000);
    check("t2_macC", bus.L_macOutC, 32'h0);
    check("t2_lmac_result", l_mac(bus.L_macOutC, bus.L_macOutA, bus.L_macOutB), 32'h20000000);
    exp_q.push_back(2'b10);
    bus.req = 2'b10;
    tick();
    check("t2_handover", 32'(bus.grant), 32'h2);
    check("t2_macA_owner1", 32'(bus.L_macOutA), 32'h1234);

    // Owner 1 starts L_shl, drops req while busy.
    bus.rq_L_shlVar1     = {32'h00010000, 32'hDEADBEEF};
    bus.rq_L_shlNumShift = {16'd3, 16'd7};
    bus.rq_L_shlReady    = 2'b10;
    #1;
    check("t3_shl_ready", 32'(bus.L_shlReady), 32'h1);
    check("t3_shl_var1", bus.L_shlVar1Out, 32'h00010000);
    check("t3_shl_shift", 32'(bus.L_shlNumShiftOut), 32'h3);
    tick();
    bus.rq_L_shlReady = '0;
    bus.req           = 2'b00;
    check("t3_busy_set", 32'(bus.busy), 32'h1);
    tick_n(2);
    check("t3_grant_held", 32'(bus.grant), 32'h2);
    check("t3_busy_held", 32'(bus.busy), 32'h1);
    bus.L_shlDone = 1'b1;
    bus.req       = 2'b01;
    #1;
    check("t3_done_out", 32'(bus.L_shlDoneOut), 32'h2);
    exp_q.push_back(2'b01);
    tick();
    bus.L_shlDone = 1'b0;
    check("t3_busy_clear", 32'(bus.busy), 32'h0);
    check("t3_grant_until_next", 32'(bus.grant), 32'h2);
    tick();
    check("t3_handover", 32'(bus.grant), 32'h1);

    // Non-owner strobe is ignored.
    bus.rq_L_shlReady = 2'b10;
    #1;
    check("t6_shl_ready_blocked", 32'(bus.L_shlReady), 32'h0);
    check("t6_var1_owner0", bus.L_shlVar1Out, 32'hDEADBEEF);
    tick();
    bus.rq_L_shlReady = '0;
    check("t6_busy_unchanged", 32'(bus.busy), 32'h0);

    // Alternating release with both requesting.
    own     = 2'b01;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick_n(3);
      exp_q.push_back(own ^ 2'b11);
      bus.req = 2'b11 & ~own;
      tick();
      own = own ^ 2'b11;
      check("t4_alternate", 32'(bus.grant), 32'(own));
      bus.req = 2'b11;
    end
    check("t4_no_hold_err", 32'(bus.hold_err), 32'h0);

    // Reset during an in-flight L_shl.
    bus.rq_L_shlReady = 2'b01;
    tick();
    bus.rq_L_shlReady = '0;
    check("rm_busy_before", 32'(bus.busy), 32'h1);
    exp_q.push_back(2'b00);
    #2;
    reset = 1'b0;
    #1;
    check("rm_grant_drop", 32'(bus.grant), 32'h0);
    check("rm_busy_drop", 32'(bus.busy), 32'h0);
    exp_q.push_back(2'b01);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rm_regrant", 32'(bus.grant), 32'h1);

    // Hold watchdog with MAX_HOLD=8.
    tick_n(7);
    check("t5_hold_err_before", 32'(bus.hold_err), 32'h0);
    tick();
    check("t5_hold_err_set", 32'(bus.hold_err), 32'h1);
    tick_n(12);
    exp_q.push_back(2'b10);
    bus.req = 2'b10;
    tick();
    check("t5_handover", 32'(bus.grant), 32'h2);
    check("t5_hold_err_sticky", 32'(bus.hold_err), 32'h1);

    // Release with nothing pending returns to idle with zeroed unit side.
    bus.rq_L_macA = {16'h5678, 16'h9ABC};
    exp_q.push_back(2'b00);
    bus.req = 2'b00;
    tick();
    bus.L_shlDone = 1'b1;
    #1;
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_macA_zero", 32'(bus.L_macOutA), 32'h0);
    check("idle_done_out", 32'(bus.L_shlDoneOut), 32'h0);
    bus.L_shlDone = 1'b0;
    tick_n(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
